riscv_v_logic_wb_stage: RTL and testbench

Writeback stage directly downstream of the vector logical ALU. It accepts each ALU result (data plus valid), folds multi-uop logical reductions (vredand/vredor across an LMUL register group) into a single result, and buffers results in a small FIFO. It then presents them to the vector register file write port under a valid/ready handshake.

---
 rtl/riscv_v_logic_wb_stage.sv | 107 ++++++++++
 tb/tb_riscv_v_logic_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_logic_wb_stage.sv
// riscv_v_logic_wb_stage: folds vector logical reductions and buffers ALU results for the VRF write port.
// Optional same-cycle bypass when empty: define RISCV_V_LOGIC_WB_BYPASS_EN.
module riscv_v_logic_wb_stage #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W/8-1:0]      in_byte_en,
   input  logic                     in_is_reduct,
   input  logic                     in_is_and,
   input  logic                     in_last,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [DATA_W-1:0]        wb_data,
   output logic [ADDR_W-1:0]        wb_addr,
   output logic [DATA_W/8-1:0]      wb_byte_en,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = DATA_W / 8;
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d, fold, enq_data, last_data;
   logic [ADDR_W-1:0] last_addr;
   logic [BW-1:0]     last_be;
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [BW-1:0]     mem_be   [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              fire, enq, push, deq, byp, empty;
   always_comb begin
      empty    = (count == '0);
      in_ready = (count != CW'(DEPTH));
      busy     = ~empty | (state_q == ACCUM);
      fire     = in_valid & in_ready;
      fold     = in_is_and ? (acc_q & in_data) : (acc_q | in_data);
      enq      = fire & (~in_is_reduct | in_last);
      enq_data = (in_is_reduct && state_q == ACCUM) ? fold : in_data;
      state_d  = state_q;
      acc_d    = acc_q;
      if (fire && in_is_reduct) begin
         state_d = in_last ? IDLE : ACCUM;
         acc_d   = in_last ? acc_q : (state_q == ACCUM ? fold : in_data);
      end
`ifdef RISCV_V_LOGIC_WB_BYPASS_EN
      // An empty FIFO lets a ready result go straight to the VRF without taking a slot.
      byp        = empty & enq & wb_ready;
      wb_valid   = ~empty | byp;
      wb_data    = ~empty ? mem_data[rd_ptr] : (byp ? enq_data   : last_data);
      wb_addr    = ~empty ? mem_addr[rd_ptr] : (byp ? in_addr    : last_addr);
      wb_byte_en = ~empty ? mem_be[rd_ptr]   : (byp ? in_byte_en : last_be);
`else
      byp        = 1'b0;
      wb_valid   = ~empty;
      wb_data    = ~empty ? mem_data[rd_ptr] : last_data;
      wb_addr    = ~empty ? mem_addr[rd_ptr] : last_addr;
      wb_byte_en = ~empty ? mem_be[rd_ptr]   : last_be;
`endif
      push      = enq & ~byp;
      deq       = ~empty & wb_ready;
      occupancy = count;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_data <= '0;
         last_addr <= '0;
         last_be   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count   <= count + CW'(push) - CW'(deq);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         // Keep the last written payload visible on wb_* once the FIFO drains.
         if (deq) begin
            last_data <= mem_data[rd_ptr];
            last_addr <= mem_addr[rd_ptr];
            last_be   <= mem_be[rd_ptr];
         end else if (byp) begin
            last_data <= enq_data;
            last_addr <= in_addr;
            last_be   <= in_byte_en;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= enq_data;
         mem_addr[wr_ptr] <= in_addr;
         mem_be[wr_ptr]   <= in_byte_en;
      end
   end
endmodule

// File: tb/tb_riscv_v_logic_wb_stage.sv
// tb_riscv_v_logic_wb_stage: directed vector table, reset-in-ACCUM sequence and randomized queue-model check.
module tb_riscv_v_logic_wb_stage;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, in_is_reduct = 1'b0, in_is_and = 1'b0, in_last = 1'b0;
   logic [127:0] in_data = '0, wb_data;
   logic [4:0] in_addr = '0, wb_addr;
   logic [15:0] in_byte_en = '0, wb_byte_en;
   logic wb_valid, wb_ready = 1'b0, busy;
   logic [1:0] occupancy;
   int total = 0, bad = 0;

   riscv_v_logic_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_addr(in_addr), .in_byte_en(in_byte_en), .in_is_reduct(in_is_reduct), .in_is_and(in_is_and),
      .in_last(in_last), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
      .wb_byte_en(wb_byte_en), .occupancy(occupancy), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic v, red, a, last, rdy;
      logic [127:0] d;
      logic [4:0] ad;
      logic ev;
      logic [127:0] ed;
      logic [4:0] ead;
      logic eir, ebusy;
      logic [1:0] eocc;
   } vec_t;

   typedef struct {
      logic [127:0] d;
      logic [4:0] ad;
      logic [15:0] be;
   } ent_t;

   function automatic vec_t mk(logic v, red, a, last, rdy, logic [127:0] d, logic [4:0] ad,
                               logic ev, logic [127:0] ed, logic [4:0] ead, logic eir, ebusy, logic [1:0] eocc);
      vec_t r;
      r.v = v; r.red = red; r.a = a; r.last = last; r.rdy = rdy; r.d = d; r.ad = ad;
      r.ev = ev; r.ed = ed; r.ead = ead; r.eir = eir; r.ebusy = ebusy; r.eocc = eocc;
      return r;
   endfunction

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   task automatic drive(input logic v, red, a, last, rdy, input logic [127:0] d, input logic [4:0] ad,
                        input logic [15:0] be);
      in_valid = v; in_is_reduct = red; in_is_and = a; in_last = last; wb_ready = rdy;
      in_data = d; in_addr = ad; in_byte_en = be;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string n);
      chk({n, "_wb_valid"}, 128'(wb_valid), 128'(0));
      chk({n, "_in_ready"}, 128'(in_ready), 128'(1));
      chk({n, "_occ"}, 128'(occupancy), 128'(0));
      chk({n, "_busy"}, 128'(busy), 128'(0));
      chk({n, "_wb_data"}, wb_data, 128'(0));
      chk({n, "_wb_addr"}, 128'(wb_addr), 128'(0));
      chk({n, "_wb_be"}, 128'(wb_byte_en), 128'(0));
   endtask

   vec_t tbl[22];
   ent_t q[$];
   ent_t last_e, e;
   logic m_acc_on;
   logic [127:0] m_acc, a5;

   initial begin
      a5 = {16{8'hA5}};
      tbl[0]  = mk(1,0,0,0,1, a5,     3, 0, 0,     0, 1,0,0);
      tbl[1]  = mk(0,0,0,0,1, 0,      0, 1, a5,    3, 1,1,1);
      tbl[2]  = mk(1,1,0,0,1, 128'h1, 7, 0, a5,    3, 1,0,0);
      tbl[3]  = mk(1,1,0,0,1, 128'h2, 7, 0, a5,    3, 1,1,0);
      tbl[4]  = mk(1,1,0,0,1, 128'h4, 7, 0, a5,    3, 1,1,0);
      tbl[5]  = mk(1,1,0,1,1, 128'h8, 7, 0, a5,    3, 1,1,0);
      tbl[6]  = mk(0,0,0,0,1, 0,      0, 1, 128'hF, 7, 1,1,1);
      tbl[7]  = mk(0,0,0,0,1, 0,      0, 0, 128'hF, 7, 1,0,0);
      tbl[8]  = mk(1,1,1,0,1, 128'hFF, 9, 0, 128'hF, 7, 1,0,0);
      tbl[9]  = mk(1,0,0,0,1, 128'h55, 2, 0, 128'hF, 7, 1,1,0);
      tbl[10] = mk(1,1,1,0,1, 128'h0F, 9, 1, 128'h55, 2, 1,1,1);
      tbl[11] = mk(1,1,1,1,1, 128'h3C, 9, 0, 128'h55, 2, 1,1,0);
      tbl[12] = mk(0,0,0,0,1, 0,      0, 1, 128'h0C, 9, 1,1,1);
      tbl[13] = mk(0,0,0,0,1, 0,      0, 0, 128'h0C, 9, 1,0,0);
      tbl[14] = mk(1,0,0,0,0, 128'h11, 1, 0, 128'h0C, 9, 1,0,0);
      tbl[15] = mk(1,0,0,0,0, 128'h22, 2, 1, 128'h11, 1, 1,1,1);
      tbl[16] = mk(1,0,0,0,0, 128'h33, 3, 1, 128'h11, 1, 0,1,2);
      tbl[17] = mk(1,0,0,0,1, 128'h33, 3, 1, 128'h11, 1, 0,1,2);
      tbl[18] = mk(1,0,0,0,0, 128'h33, 3, 1, 128'h22, 2, 1,1,1);
      tbl[19] = mk(0,0,0,0,1, 0,      0, 1, 128'h22, 2, 0,1,2);
      tbl[20] = mk(0,0,0,0,1, 0,      0, 1, 128'h33, 3, 1,1,1);
      tbl[21] = mk(0,0,0,0,1, 0,      0, 0, 128'h33, 3, 1,0,0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("reset_held");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_reset("reset_release");
      adv();

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].v, tbl[i].red, tbl[i].a, tbl[i].last, tbl[i].rdy, tbl[i].d, tbl[i].ad, 16'hFFFF);
         chk($sformatf("row%0d_wb_valid", i), 128'(wb_valid), 128'(tbl[i].ev));
         chk($sformatf("row%0d_wb_data", i), wb_data, tbl[i].ed);
         chk($sformatf("row%0d_wb_addr", i), 128'(wb_addr), 128'(tbl[i].ead));
         chk($sformatf("row%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].eir));
         chk($sformatf("row%0d_busy", i), 128'(busy), 128'(tbl[i].ebusy));
         chk($sformatf("row%0d_occ", i), 128'(occupancy), 128'(tbl[i].eocc));
         adv();
      end

      // Reset while accumulating with a full FIFO, then check a fresh reduction is clean.
      drive(1,1,1,0,0, 128'hF0, 4, 16'hFFFF); adv();
      drive(1,0,0,0,0, 128'hAA, 5, 16'hFFFF); adv();
      drive(1,0,0,0,0, 128'hBB, 6, 16'hFFFF);
      chk("pre_rst_occ", 128'(occupancy), 128'(1));
      adv();
      drive(0,0,0,0,0, 0, 0, 0);
      chk("pre_rst_full_occ", 128'(occupancy), 128'(2));
      chk("pre_rst_busy", 128'(busy), 128'(1));
      adv();
      rst_n = 1'b0;
      #1 chk_reset("rst_in_accum");
      @(negedge clk);
      chk_reset("rst_in_accum_held");
      adv();
      rst_n = 1'b1;
      drive(1,1,0,0,1, 128'h3, 8, 16'h00FF);
      chk("post_rst_r1_busy", 128'(busy), 128'(0));
      adv();
      drive(1,1,0,1,1, 128'h4, 8, 16'h00FF);
      chk("post_rst_r2_busy", 128'(busy), 128'(1));
      chk("post_rst_r2_valid", 128'(wb_valid), 128'(0));
      adv();
      drive(0,0,0,0,1, 0, 0, 0);
      chk("post_rst_wb_valid", 128'(wb_valid), 128'(1));
      chk("post_rst_wb_data", wb_data, 128'h7);
      chk("post_rst_wb_addr", 128'(wb_addr), 128'(8));
      chk("post_rst_wb_be", 128'(wb_byte_en), 128'h00FF);
      adv();

      // Randomized run against a queue-level model.
      rst_n = 1'b0;
      adv();
      rst_n = 1'b1;
      q.delete();
      last_e = '{d: '0, ad: '0, be: '0};
      m_acc_on = 1'b0;
      m_acc = '0;
      for (int c = 0; c < 3000; c++) begin
         logic v, red, a, last, rdy, fire, prod;
         logic [127:0] d, res;
         v = ($urandom_range(0, 3) != 0);
         red = ($urandom_range(0, 1) == 1);
         a = $urandom_range(0, 1);
         last = ($urandom_range(0, 2) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         d = {$urandom, $urandom, $urandom, $urandom};
         e.ad = 5'($urandom);
         e.be = 16'($urandom);
         drive(v, red, a, last, rdy, d, e.ad, e.be);
         chk("rnd_in_ready", 128'(in_ready), 128'(q.size() != 2));
         chk("rnd_wb_valid", 128'(wb_valid), 128'(q.size() != 0));
         chk("rnd_busy", 128'(busy), 128'((q.size() != 0) || m_acc_on));
         chk("rnd_occ", 128'(occupancy), 128'(q.size()));
         chk("rnd_wb_data", wb_data, q.size() != 0 ? q[0].d : last_e.d);
         chk("rnd_wb_addr", 128'(wb_addr), 128'(q.size() != 0 ? q[0].ad : last_e.ad));
         chk("rnd_wb_be", 128'(wb_byte_en), 128'(q.size() != 0 ? q[0].be : last_e.be));
         fire = v && (q.size() < 2);
         prod = fire && (!red || last);
         res = d;
         if (fire && red) begin
            if (m_acc_on) res = a ? (m_acc & d) : (m_acc | d);
            if (!last) m_acc = res;
            m_acc_on = !last;
         end
         if (rdy && q.size() != 0) last_e = q.pop_front();
         if (prod) begin
            e.d = res;
            q.push_back(e);
         end
         adv();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
